// File: rtl/bus_datapath_gen_if.sv
// bus_datapath_gen_if: control/bus bundle between the control unit (master) and bus_datapath_gen (slave).
//   master drives register enables, bus selects, external bus sources, opcode and IncPC/BAout;
//   slave drives bus_mux_out, out_port_data and the busy/done/div0/bus_conflict status.
interface bus_datapath_gen_if #(
    parameter int WIDTH = 32,
    parameter int NREGS = 16
);
    logic [NREGS-1:0] reg_in, reg_out;
    logic hi_in, lo_in, y_in, hi_out, lo_out, zhigh_out, zlow_out, z_in;
    logic pc_out, mdr_out, in_port_out, c_out;
    logic [WIDTH-1:0] bus_mux_in_pc, bus_mux_in_mdr, c_sign_extended, in_port_data_in;
    logic in_port_en, out_port_en, inc_pc, ba_out;
    logic [4:0] opcode;
    logic [WIDTH-1:0] bus_mux_out, out_port_data;
    logic busy, done, div0, bus_conflict;
    modport master (
        output reg_in, reg_out, hi_in, lo_in, y_in, hi_out, lo_out, zhigh_out, zlow_out, z_in,
               pc_out, mdr_out, in_port_out, c_out, bus_mux_in_pc, bus_mux_in_mdr, c_sign_extended,
               in_port_data_in, in_port_en, out_port_en, inc_pc, ba_out, opcode,
        input  bus_mux_out, out_port_data, busy, done, div0, bus_conflict
    );
    modport slave (
        input  reg_in, reg_out, hi_in, lo_in, y_in, hi_out, lo_out, zhigh_out, zlow_out, z_in,
               pc_out, mdr_out, in_port_out, c_out, bus_mux_in_pc, bus_mux_in_mdr, c_sign_extended,
               in_port_data_in, in_port_en, out_port_en, inc_pc, ba_out, opcode,
        output bus_mux_out, out_port_data, busy, done, div0, bus_conflict
    );
endinterface

// File: rtl/bus_datapath_gen.sv
// bus_datapath_gen: single-bus CPU datapath with NREGS registers, HI/LO/Y/Z, priority bus mux and iterative MUL/DIV.
//   clock : rising-edge clock
//   clear : asynchronous active-low reset
//   dp    : bus_datapath_gen_if.slave (enables, selects, bus sources, opcode in; bus, out port, status out)
//   Option macro DP_FAST_MUL_EN: MUL completes in one cycle instead of the WIDTH-step sequencer.
module bus_datapath_gen #(
    parameter int WIDTH = 32,
    parameter int NREGS = 16
) (
    input logic clock,
    input logic clear,
    bus_datapath_gen_if.slave dp
);
    localparam int SW = $clog2(WIDTH);
    localparam int NS = NREGS + 8;
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
`ifdef DP_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction
    logic [WIDTH-1:0] r [NREGS];
    logic [WIDTH-1:0] hi, lo, y, in_port, out_port, bus_val;
    logic [2*WIDTH-1:0] z, alu, pr, res;
    logic signed [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] src [NS];
    logic [NS-1:0] sel;
    logic conflict, bus_conflict, div0, done, start, ld_z;
    logic [1:0] state;
    logic [SW-1:0] cnt, sh;
    logic [SW:0] shc;
    logic [WIDTH-1:0] a, b, ma, mb, ph, pl, a_raw, ph_n, pl_n, q, rm;
    logic [WIDTH:0] msum, dt, ddif;
    logic neg, is_div, dz;
    assign sel = {dp.c_out, dp.in_port_out, dp.mdr_out, dp.pc_out, dp.zlow_out, dp.zhigh_out,
                  dp.lo_out, dp.hi_out, dp.reg_out};
    always_comb begin
        src[0] = dp.ba_out ? '0 : r[0];
        for (int i = 1; i < NREGS; i++) src[i] = r[i];
        src[NREGS]   = hi;
        src[NREGS+1] = lo;
        src[NREGS+2] = z[2*WIDTH-1:WIDTH];
        src[NREGS+3] = z[WIDTH-1:0];
        src[NREGS+4] = dp.bus_mux_in_pc;
        src[NREGS+5] = dp.bus_mux_in_mdr;
        src[NREGS+6] = in_port;
        src[NREGS+7] = dp.c_sign_extended;
    end
    // Walk from the highest index down so the lowest asserted select wins.
    always_comb begin
        bus_val = '0;
        for (int i = NS - 1; i >= 0; i--) if (sel[i]) bus_val = src[i];
    end
    assign conflict = |(sel & (sel - NS'(1)));
    assign a = y;
    assign b = bus_val;
    assign sh = b[SW-1:0];
    assign shc = (SW+1)'(WIDTH) - {1'b0, sh};
    assign prod = $signed(a) * $signed(b);
    always_comb begin
        alu = '0;
        if (dp.inc_pc) alu[WIDTH-1:0] = b + WIDTH'(1);
        else case (dp.opcode)
            5'd0:  alu[WIDTH-1:0] = a + b;
            5'd1:  alu[WIDTH-1:0] = a - b;
            5'd2:  alu[WIDTH-1:0] = a & b;
            5'd3:  alu[WIDTH-1:0] = a | b;
            5'd4:  alu[WIDTH-1:0] = a >> sh;
            5'd5:  alu[WIDTH-1:0] = $signed(a) >>> sh;
            5'd6:  alu[WIDTH-1:0] = a << sh;
            5'd7:  alu[WIDTH-1:0] = (a >> sh) | (a << shc);
            5'd8:  alu[WIDTH-1:0] = (a << sh) | (a >> shc);
            5'd9:  alu[WIDTH-1:0] = -b;
            5'd10: alu[WIDTH-1:0] = ~b;
            5'd11: alu = FAST ? prod : '0;
            default: alu = '0;
        endcase
    end
    assign start = dp.z_in && !dp.inc_pc && state != RUN &&
                   (dp.opcode == 5'd12 || (dp.opcode == 5'd11 && !FAST));
    assign ld_z = dp.z_in && state != RUN && !start;
    // MUL: shift-add with ph:pl as product/multiplier. DIV: restoring, ph = remainder, pl = dividend/quotient.
    assign msum = {1'b0, ph} + (pl[0] ? {1'b0, ma} : '0);
    assign dt = {ph, pl[WIDTH-1]};
    assign ddif = dt - {1'b0, mb};
    assign ph_n = is_div ? (ddif[WIDTH] ? dt[WIDTH-1:0] : ddif[WIDTH-1:0]) : msum[WIDTH:1];
    assign pl_n = is_div ? {pl[WIDTH-2:0], ~ddif[WIDTH]} : {msum[0], pl[WIDTH-1:1]};
    assign pr = {ph_n, pl_n};
    assign q = neg ? -pl_n : pl_n;
    assign rm = a_raw[WIDTH-1] ? -ph_n : ph_n;
    assign res = !is_div ? (neg ? -pr : pr) : dz ? {a_raw, {WIDTH{1'b1}}} : {rm, q};
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < NREGS; i++) r[i] <= '0;
            hi <= '0;
            lo <= '0;
            y <= '0;
            z <= '0;
            in_port <= '0;
            out_port <= '0;
            state <= IDLE;
            cnt <= '0;
            ma <= '0;
            mb <= '0;
            ph <= '0;
            pl <= '0;
            a_raw <= '0;
            neg <= 1'b0;
            is_div <= 1'b0;
            dz <= 1'b0;
            done <= 1'b0;
            div0 <= 1'b0;
            bus_conflict <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) if (dp.reg_in[i]) r[i] <= bus_val;
            if (dp.hi_in) hi <= bus_val;
            if (dp.lo_in) lo <= bus_val;
            if (dp.y_in) y <= bus_val;
            if (dp.in_port_en) in_port <= dp.in_port_data_in;
            if (dp.out_port_en) out_port <= bus_val;
            if (conflict) bus_conflict <= 1'b1;
            done <= 1'b0;
            if (ld_z) begin
                z <= alu;
                done <= FAST && dp.opcode == 5'd11 && !dp.inc_pc;
            end
            if (start) begin
                state <= RUN;
                cnt <= '0;
                a_raw <= a;
                ma <= mag(a);
                mb <= mag(b);
                ph <= '0;
                pl <= dp.opcode == 5'd12 ? mag(a) : mag(b);
                neg <= a[WIDTH-1] ^ b[WIDTH-1];
                is_div <= dp.opcode == 5'd12;
                dz <= b == '0;
            end else if (state == RUN) begin
                ph <= ph_n;
                pl <= pl_n;
                cnt <= cnt + SW'(1);
                if (cnt == SW'(WIDTH - 1)) begin
                    state <= DONE;
                    z <= res;
                    done <= 1'b1;
                    if (is_div && dz) div0 <= 1'b1;
                end
            end else state <= IDLE;
        end
    end
    assign dp.bus_mux_out = bus_val;
    assign dp.out_port_data = out_port;
    assign dp.busy = state == RUN;
    assign dp.done = done;
    assign dp.div0 = div0;
    assign dp.bus_conflict = bus_conflict;
endmodule
